// File: rtl/inc_seq_pkg.sv
// Shared types and default sizing for the increment sequencer and its arbiter.
// Used by increment_sequencer and inc_arbiter.
package inc_seq_pkg;

    localparam int DEF_WIDTH         = 16;
    localparam int DEF_SETTLE_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        SETTLE = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef enum logic {
        REQ_PC = 1'b0,
        REQ_XY = 1'b1
    } req_id_t;

    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_PC) ? REQ_XY : REQ_PC;
    endfunction

endpackage

// File: rtl/inc_arbiter.sv
// Picks which requester owns the shared incrementer for the next operation.
// Build option INC_SEQ_ROUND_ROBIN_EN: alternate on contention instead of fixed PC priority.
module inc_arbiter
    import inc_seq_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    pc_req,
    input  logic    xy_req,
    input  logic    grant_en,
    output req_id_t grant
);

`ifdef INC_SEQ_ROUND_ROBIN_EN
    req_id_t rr_q;
    req_id_t rr_d;

    // Pointer names the winner on contention; after any grant it points away from the winner.
    always_comb begin
        grant = pc_req ? REQ_PC : REQ_XY;
        if (pc_req && xy_req) begin
            grant = rr_q;
        end
        rr_d = rr_q;
        if (grant_en) begin
            rr_d = other_req(grant);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q <= REQ_PC;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    logic unused_arb;
    assign unused_arb = ^{clock, reset, grant_en};

    always_comb begin
        grant = pc_req ? REQ_PC : REQ_XY;
    end
`endif

endmodule

// File: rtl/increment_sequencer.sv
// Time-shares one WIDTH-bit incrementer between the PC and XY registers via the address bus.
// Build option INC_SEQ_ROUND_ROBIN_EN selects round-robin arbitration (see inc_arbiter).
module increment_sequencer
    import inc_seq_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pc_req,
    input  logic             xy_req,
    input  logic [WIDTH-1:0] addr_bus_in,
    output logic             pc_ack,
    output logic             xy_ack,
    output logic             busy,
    output logic             sel_pc,
    output logic             sel_xy,
    output logic             drive_inc,
    output logic             ld_pc,
    output logic             ld_xy,
    output logic [WIDTH-1:0] inc_result,
    output logic             wrap
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_t            state_q, state_d;
    req_id_t           grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  inc_reg_q, inc_reg_d;
    logic              wrap_q, wrap_d;
    logic              grant_en;
    req_id_t           arb_grant;

    inc_arbiter u_arbiter (
        .clock    (clock),
        .reset    (reset),
        .pc_req   (pc_req),
        .xy_req   (xy_req),
        .grant_en (grant_en),
        .grant    (arb_grant)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        inc_reg_d = inc_reg_q;
        wrap_d    = wrap_q;
        grant_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pc_req || xy_req) begin
                    grant_en = 1'b1;
                    grant_d  = arb_grant;
                    state_d  = SELECT;
                end
            end
            SELECT: begin
                inc_reg_d = addr_bus_in;
                cnt_d     = '0;
                state_d   = (SETTLE_CYCLES == 0) ? WRITE : SETTLE;
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WRITE: begin
                // Carry out of the incrementer happens exactly when the source is all-ones.
                wrap_d  = &inc_reg_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes depend only on registered state so the bus drivers never see glitches.
    always_comb begin
        sel_pc    = 1'b0;
        sel_xy    = 1'b0;
        drive_inc = 1'b0;
        ld_pc     = 1'b0;
        ld_xy     = 1'b0;
        pc_ack    = 1'b0;
        xy_ack    = 1'b0;
        case (state_q)
            SELECT: begin
                sel_pc = (grant_q == REQ_PC);
                sel_xy = (grant_q == REQ_XY);
            end
            WRITE: begin
                drive_inc = 1'b1;
                ld_pc     = (grant_q == REQ_PC);
                ld_xy     = (grant_q == REQ_XY);
            end
            DONE: begin
                pc_ack = (grant_q == REQ_PC);
                xy_ack = (grant_q == REQ_XY);
            end
            default: begin
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign inc_result = inc_reg_q + WIDTH'(1);
    assign wrap       = wrap_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= REQ_PC;
            cnt_q     <= '0;
            inc_reg_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            inc_reg_q <= inc_reg_d;
            wrap_q    <= wrap_d;
        end
    end

endmodule
